// File: rtl/monster_spawn_gen.sv
// LFSR-driven monster spawn scheduler: one-cycle lane pulses at a shrinking interval.
// Optional macro SPAWN_REROUTE_EN: an occupied preferred lane reroutes to the next free lane.
module monster_spawn_gen #(
  parameter logic [15:0] SEED          = 16'hACE1,
  parameter logic [7:0]  BASE_INTERVAL = 8'd20,
  parameter logic [7:0]  MIN_INTERVAL  = 8'd4,
  parameter logic [7:0]  RAMP_STEP     = 8'd2,
  parameter logic [3:0]  RAMP_EVERY    = 4'd5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       play_flag,
  input  logic       game_over,
  input  logic       tick,
  input  logic [3:0] occupied,
  output logic [3:0] spawn,
  output logic [3:0] level,
  output logic       active
);

  localparam logic [15:0] SEED_NZ   = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [8:0]  RAMP_SUM  = {1'b0, RAMP_STEP} + {1'b0, MIN_INTERVAL};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SPAWN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  interval_q, interval_d;
  logic [7:0]  count_q, count_d;
  logic [3:0]  attempts_q, attempts_d;
  logic [3:0]  level_q, level_d;
  logic [3:0]  spawn_q, spawn_d;
  logic        abort;
  logic [1:0]  pref;
  logic [3:0]  lane_pulse;
  logic [7:0]  ramp_interval;
  logic [3:0]  attempts_inc;

  assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
  assign abort  = game_over | ~play_flag;
  assign pref   = lfsr_q[1:0];
  assign attempts_inc = attempts_q + 4'd1;

  // 9-bit compare so interval - RAMP_STEP never wraps below the floor.
  assign ramp_interval = ({1'b0, interval_q} < RAMP_SUM) ? MIN_INTERVAL
                                                         : (interval_q - RAMP_STEP);

`ifdef SPAWN_REROUTE_EN
  logic [1:0] alt;
  always_comb begin
    lane_pulse = 4'b0000;
    alt        = 2'd0;
    if (!occupied[pref]) begin
      lane_pulse[pref] = 1'b1;
    end else begin
      // Walk farthest-to-nearest so the nearest free lane is the one left standing.
      for (int k = 3; k >= 1; k--) begin
        alt = pref + 2'(k);
        if (!occupied[alt]) begin
          lane_pulse      = 4'b0000;
          lane_pulse[alt] = 1'b1;
        end
      end
    end
  end
`else
  always_comb begin
    lane_pulse = 4'b0000;
    if (!occupied[pref]) lane_pulse[pref] = 1'b1;
  end
`endif

  always_comb begin
    state_d    = state_q;
    interval_d = interval_q;
    count_d    = count_q;
    attempts_d = attempts_q;
    level_d    = level_q;
    spawn_d    = 4'b0000;

    case (state_q)
      S_IDLE: begin
        interval_d = BASE_INTERVAL;
        count_d    = BASE_INTERVAL;
        attempts_d = 4'd0;
        level_d    = 4'd0;
        if (!abort) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (count_q > 8'd1) begin
            count_d = count_q - 8'd1;
          end else begin
            state_d = S_SPAWN;
            spawn_d = lane_pulse;
          end
        end
      end
      S_SPAWN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
          if (attempts_inc == RAMP_EVERY) begin
            attempts_d = 4'd0;
            level_d    = (level_q == 4'hF) ? level_q : level_q + 4'd1;
            interval_d = ramp_interval;
            count_d    = ramp_interval;
          end else begin
            attempts_d = attempts_inc;
            count_d    = interval_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Leaving for IDLE clears the game context on the same edge as the abort.
    if (state_d == S_IDLE) begin
      interval_d = BASE_INTERVAL;
      count_d    = BASE_INTERVAL;
      attempts_d = 4'd0;
      level_d    = 4'd0;
      spawn_d    = 4'b0000;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      lfsr_q     <= SEED_NZ;
      interval_q <= BASE_INTERVAL;
      count_q    <= BASE_INTERVAL;
      attempts_q <= 4'd0;
      level_q    <= 4'd0;
      spawn_q    <= 4'b0000;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      interval_q <= interval_d;
      count_q    <= count_d;
      attempts_q <= attempts_d;
      level_q    <= level_d;
      spawn_q    <= spawn_d;
    end
  end

  assign spawn  = spawn_q;
  assign level  = level_q;
  assign active = (state_q == S_WAIT) || (state_q == S_SPAWN);

endmodule

// File: tb/tb_monster_spawn_gen.sv
// Scoreboard bench for monster_spawn_gen: driver queues expected pulses, monitor checks them.
module tb_monster_spawn_gen;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       play_flag = 1'b0;
  logic       game_over = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] occupied = 4'b0000;
  logic [3:0] spawn;
  logic [3:0] level;
  logic       active;

  monster_spawn_gen #(
    .SEED(16'hACE1), .BASE_INTERVAL(8'd4), .MIN_INTERVAL(8'd2),
    .RAMP_STEP(8'd1), .RAMP_EVERY(4'd2)
  ) dut (
    .Clk(Clk), .Reset(Reset), .play_flag(play_flag), .game_over(game_over),
    .tick(tick), .occupied(occupied), .spawn(spawn), .level(level), .active(active)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0] spawn;
    logic [3:0] level;
    int         cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          exp_pulses = 0;
  int          seen_pulses = 0;
  logic [3:0]  prev_spawn = 4'b0000;
  logic [15:0] m_lfsr;

  // Reference LFSR kept in lockstep with the DUT clock and reset.
  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_lfsr <= 16'hACE1;
      cyc    <= 0;
    end else begin
      m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
      cyc    <= cyc + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0d", name, act);
    end
  endtask

  function automatic logic [3:0] exp_spawn(input logic [1:0] lane, input logic [3:0] occ);
    logic [3:0] r;
    logic [1:0] l;
    r = 4'b0000;
    l = lane;
    if (!occ[lane]) r[lane] = 1'b1;
`ifdef SPAWN_REROUTE_EN
    else begin
      for (int k = 1; k <= 3; k++) begin
        l = lane + 2'(k);
        if (!occ[l] && r == 4'b0000) r[l] = 1'b1;
      end
    end
`endif
    return r;
  endfunction

  // Monitor: every nonzero spawn must match the head of the scoreboard.
  always @(negedge Clk) begin
    if (Reset) begin
      if (spawn != 4'b0000) begin
        seen_pulses++;
        check("spawn_onehot", 32'($onehot(spawn)), 32'd1);
        check("spawn_width_prev", {28'd0, prev_spawn}, 32'd0);
        if (sb_q.size() == 0) begin
          check("unexpected_pulse", {28'd0, spawn}, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("spawn_lane", {28'd0, spawn}, {28'd0, mon_e.spawn});
          check("spawn_level", {28'd0, level}, {28'd0, mon_e.level});
          check("spawn_cycle", cyc, mon_e.cyc);
        end
      end
      prev_spawn = spawn;
    end else begin
      prev_spawn = 4'b0000;
    end
  end

  // mode: 0 normal, 1 game_over on last tick, 2 play_flag drop in SPAWN cycle, 3 expect nothing
  task automatic run_gap(input int n, input logic [3:0] occ, input logic [3:0] lvl, input int mode);
    logic [3:0] x;
    exp_t       ent;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      tick     = 1'b1;
      occupied = occ;
      if (i == n - 1) begin
        if (mode == 1) begin
          game_over = 1'b1;
        end else if (mode != 3) begin
          x = exp_spawn(m_lfsr[1:0], occ);
          if (x != 4'b0000) begin
            ent.spawn = x;
            ent.level = lvl;
            ent.cyc   = cyc + 1;
            sb_q.push_back(ent);
            exp_pulses++;
          end
        end
      end
      @(negedge Clk);
      tick = 1'b0;
      if (i == n - 1 && mode == 1) begin
        game_over = 1'b0;
        check("abort_active", {31'd0, active}, 32'd0);
        check("abort_spawn", {28'd0, spawn}, 32'd0);
      end
      if (i == n - 1 && mode == 2) play_flag = 1'b0;
      @(negedge Clk);
      if (i == n - 1 && mode == 2) begin
        check("drop_active", {31'd0, active}, 32'd0);
        check("drop_level", {28'd0, level}, 32'd0);
      end
    end
  endtask

  task automatic restart();
    @(negedge Clk);
    play_flag = 1'b0;
    @(negedge Clk);
    play_flag = 1'b1;
  endtask

  int gaps[7]   = '{4, 4, 3, 3, 2, 2, 2};
  int levels[7] = '{0, 0, 1, 1, 2, 2, 3};

  initial begin
    repeat (2) @(negedge Clk);
    check("reset_spawn", {28'd0, spawn}, 32'd0);
    check("reset_level", {28'd0, level}, 32'd0);
    check("reset_active", {31'd0, active}, 32'd0);
    Reset = 1'b1;
    @(negedge Clk);
    check("idle_active", {31'd0, active}, 32'd0);
    play_flag = 1'b1;
    @(negedge Clk);
    check("start_active", {31'd0, active}, 32'd1);

    // Ramp: gaps 4,4,3,3,2,2,2 with level stepping every two attempts.
    for (int k = 0; k < 7; k++) begin
      run_gap(gaps[k], 4'b0000, 4'(levels[k]), 0);
      if (k == 1) check("ramp_level1", {28'd0, level}, 32'd1);
      if (k == 3) check("ramp_level2", {28'd0, level}, 32'd2);
      if (k == 5) check("ramp_level3", {28'd0, level}, 32'd3);
    end
    check("ramp_level_end", {28'd0, level}, 32'd3);
    check("ramp_drain", sb_q.size(), 32'd0);

    // Asynchronous reset mid-WAIT, then release with play_flag high.
    @(negedge Clk); tick = 1'b1;
    @(negedge Clk); tick = 1'b0;
    #2 Reset = 1'b0;
    #1;
    check("async_active", {31'd0, active}, 32'd0);
    check("async_level", {28'd0, level}, 32'd0);
    check("async_spawn", {28'd0, spawn}, 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    #1 check("release_active0", {31'd0, active}, 32'd0);
    @(negedge Clk);
    check("release_active1", {31'd0, active}, 32'd1);

    // Lanes 0..2 busy: drop or reroute depending on build.
    for (int k = 0; k < 6; k++) run_gap(gaps[k], 4'b0111, 4'(levels[k]), 0);
    check("occ_level", {28'd0, level}, 32'd3);
    check("occ_drain", sb_q.size(), 32'd0);
    check("occ_pulse_count", seen_pulses, exp_pulses);

    // All lanes busy: no pulses, attempts still ramp.
    restart();
    @(negedge Clk);
    check("full_restart_level", {28'd0, level}, 32'd0);
    check("full_restart_active", {31'd0, active}, 32'd1);
    run_gap(4, 4'hF, 4'd0, 0);
    run_gap(4, 4'hF, 4'd0, 0);
    check("full_level", {28'd0, level}, 32'd1);

    // Abort on the 4th tick, then replay from base interval.
    restart();
    run_gap(4, 4'b0000, 4'd0, 1);
    check("abort_level", {28'd0, level}, 32'd0);
    run_gap(4, 4'b0000, 4'd0, 0);
    check("replay_level", {28'd0, level}, 32'd0);

    // play_flag drop during SPAWN: pulse allowed, nothing afterwards.
    run_gap(4, 4'b0000, 4'd0, 2);
    run_gap(4, 4'b0000, 4'd0, 3);
    check("post_drop_active", {31'd0, active}, 32'd0);

    repeat (2) @(negedge Clk);
    check("final_drain", sb_q.size(), 32'd0);
    check("final_pulse_count", seen_pulses, exp_pulses);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
